// File: rtl/axis_tg_pkg.sv
// Shared types and payload layout for the AXI-Stream traffic generator.
package axis_tg_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_DONE} tg_state_e;

  // Payload layout below the source-id field, which sits at the top of tdata.
  localparam int PKT_LSB  = 8;
  localparam int PKT_W    = 8;
  localparam int BEAT_LSB = 0;
  localparam int BEAT_W   = 8;

  function automatic logic [7:0] clamp_len(input logic [7:0] len);
    return (len == 8'd0) ? 8'd1 : len;
  endfunction

endpackage

// File: rtl/axis_traffic_gen_if.sv
// AXI-Stream output bundle of the traffic generator.
interface axis_traffic_gen_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TDEST_WIDTH = 4
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tdest, output tready);
endinterface

// File: rtl/axis_tg_dest_sel.sv
// Round-robin find-first-set: first set mask bit at or after ptr, wrapping.
module axis_tg_dest_sel #(
  parameter int NUM_NODES   = 4,
  parameter int TDEST_WIDTH = 4
) (
  input  logic [NUM_NODES-1:0]   mask,
  input  logic [TDEST_WIDTH-1:0] ptr,
  output logic [TDEST_WIDTH-1:0] dest,
  output logic                   found
);
  always_comb begin
    int idx;
    dest  = '0;
    found = 1'b0;
    // Walk from the farthest offset down so the nearest hit wins.
    for (int k = NUM_NODES - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_NODES;
      if (mask[idx]) begin
        dest  = TDEST_WIDTH'(idx);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axis_traffic_gen.sv
// Per-node AXI-Stream packet generator with self-describing payloads,
// round-robin destinations and saturating statistics.
module axis_traffic_gen
  import axis_tg_pkg::*;
#(
  parameter int TDATA_WIDTH      = 32,
  parameter int TDEST_WIDTH      = 4,
  parameter int SRC_ID           = 0,
  parameter int NUM_NODES        = 4,
  parameter int DISABLE_SELFLOOP = 0,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [15:0]           cfg_num_pkts,
  input  logic [7:0]            cfg_pkt_len,
  input  logic [7:0]            cfg_gap,
  input  logic [NUM_NODES-1:0]  cfg_dest_mask,
  axis_traffic_gen_if.master    axis_out,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  stat_pkts,
  output logic [CNT_WIDTH-1:0]  stat_beats,
  output logic [CNT_WIDTH-1:0]  stat_stall
);
  tg_state_e state_q, state_d;
  logic [15:0]            num_pkts_q, num_pkts_d, pkt_idx_q, pkt_idx_d;
  logic [7:0]             len_q, len_d, gap_q, gap_d, beat_q, beat_d, gap_cnt_q, gap_cnt_d;
  logic [NUM_NODES-1:0]   mask_q, mask_d, eff_mask, sel_mask;
  logic [TDEST_WIDTH-1:0] rr_ptr_q, rr_ptr_d, dest_q, dest_d, sel_dest;
  logic [CNT_WIDTH-1:0]   pkts_q, pkts_d, beats_q, beats_d, stall_q, stall_d;
  logic sel_found, send, start_acc, xfer, last_beat, last_xfer;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign eff_mask  = (DISABLE_SELFLOOP != 0) ? (cfg_dest_mask & ~(NUM_NODES'(1) << SRC_ID))
                                             : cfg_dest_mask;
  assign send      = (state_q == ST_SEND);
  assign start_acc = cfg_start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign xfer      = send && axis_out.tready;
  assign last_beat = (beat_q == len_q - 8'd1);
  assign last_xfer = xfer && last_beat;

  // Pointer for the next packet is known before its destination is chosen,
  // which lets a zero-gap packet follow tlast with no bubble.
  assign rr_ptr_d = start_acc ? '0
                  : last_xfer ? ((dest_q == TDEST_WIDTH'(NUM_NODES - 1)) ? '0 : dest_q + 1'b1)
                  : rr_ptr_q;
  assign sel_mask = start_acc ? eff_mask : mask_q;

  axis_tg_dest_sel #(.NUM_NODES(NUM_NODES), .TDEST_WIDTH(TDEST_WIDTH)) u_dest_sel (
    .mask(sel_mask), .ptr(rr_ptr_d), .dest(sel_dest), .found(sel_found)
  );

  always_comb begin
    state_d    = state_q;
    num_pkts_d = num_pkts_q;
    len_d      = len_q;
    gap_d      = gap_q;
    mask_d     = mask_q;
    pkt_idx_d  = pkt_idx_q;
    beat_d     = beat_q;
    gap_cnt_d  = gap_cnt_q;
    dest_d     = dest_q;
    pkts_d     = pkts_q;
    beats_d    = beats_q;
    stall_d    = stall_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) begin
          num_pkts_d = cfg_num_pkts;
          len_d      = clamp_len(cfg_pkt_len);
          gap_d      = cfg_gap;
          mask_d     = eff_mask;
          pkt_idx_d  = '0;
          beat_d     = '0;
          pkts_d     = '0;
          beats_d    = '0;
          stall_d    = '0;
          if (sel_found) begin
            state_d = ST_SEND;
            dest_d  = sel_dest;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SEND: begin
        if (!axis_out.tready) stall_d = sat_inc(stall_q);
        if (xfer) begin
          beat_d  = beat_q + 8'd1;
          beats_d = sat_inc(beats_q);
        end
        if (last_xfer) begin
          beat_d    = '0;
          pkt_idx_d = pkt_idx_q + 16'd1;
          pkts_d    = sat_inc(pkts_q);
          if ((num_pkts_q != 16'd0 && pkt_idx_q + 16'd1 == num_pkts_q) || cfg_abort) begin
            state_d = ST_DONE;
          end else if (gap_q == 8'd0) begin
            dest_d = sel_dest;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q;
          end
        end
      end
      ST_GAP: begin
        if (cfg_abort) begin
          state_d = ST_DONE;
        end else if (gap_cnt_q == 8'd1) begin
          state_d = ST_SEND;
          dest_d  = sel_dest;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      num_pkts_q <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      mask_q     <= '0;
      pkt_idx_q  <= '0;
      beat_q     <= '0;
      gap_cnt_q  <= '0;
      rr_ptr_q   <= '0;
      dest_q     <= '0;
      pkts_q     <= '0;
      beats_q    <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      num_pkts_q <= num_pkts_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      mask_q     <= mask_d;
      pkt_idx_q  <= pkt_idx_d;
      beat_q     <= beat_d;
      gap_cnt_q  <= gap_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      dest_q     <= dest_d;
      pkts_q     <= pkts_d;
      beats_q    <= beats_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    axis_out.tdata = '0;
    if (send) begin
      axis_out.tdata[TDATA_WIDTH-1 -: TDEST_WIDTH] = TDEST_WIDTH'(SRC_ID);
      axis_out.tdata[PKT_LSB +: PKT_W]             = pkt_idx_q[7:0];
      axis_out.tdata[BEAT_LSB +: BEAT_W]           = beat_q;
    end
  end

  assign axis_out.tvalid = send;
  assign axis_out.tlast  = send && last_beat;
  assign axis_out.tdest  = dest_q;
  assign busy            = send || (state_q == ST_GAP);
  assign done            = (state_q == ST_DONE);
  assign stat_pkts       = pkts_q;
  assign stat_beats      = beats_q;
  assign stat_stall      = stall_q;
endmodule

// File: doc/axis_traffic_gen.md
Name: axis_traffic_gen

Overview:
Per-node AXI-Stream packet generator that drives one axis_in_* port of axis_mesh (user clock domain) for NoC bring-up and throughput measurement. It emits software-configured packets with self-describing payloads, so a downstream sink can check source, packet order and beat order. Destinations are chosen round-robin from a runtime mask. One instance sits on each mesh node's input.

Parameters:
TDATA_WIDTH, 32, payload width; must be >= TDEST_WIDTH+16
TDEST_WIDTH, 4, destination field width
SRC_ID, 0, this node's index; embedded in payload and used for self-loop exclusion
NUM_NODES, 4, number of mesh endpoints; NUM_NODES <= 2**TDEST_WIDTH
DISABLE_SELFLOOP, 0, 1 = never target SRC_ID even if the mask bit is set
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  in  1  user clock; one clock only
rst  in  1  synchronous, active-high reset
cfg_start  in  1  one-cycle pulse; sampled only in IDLE or DONE
cfg_abort  in  1  level; stop at the next packet boundary
cfg_num_pkts  in  16  packets to send; 0 = run until abort
cfg_pkt_len  in  8  beats per packet; 0 is treated as 1
cfg_gap  in  8  idle cycles between packets
cfg_dest_mask  in  NUM_NODES  eligible destinations
axis_out_tvalid  out  1  stream valid
axis_out_tready  in  1  stream ready
axis_out_tdata  out  TDATA_WIDTH  payload
axis_out_tlast  out  1  last beat of packet
axis_out_tdest  out  TDEST_WIDTH  destination node
busy  out  1  high in SEND or GAP
done  out  1  high in DONE
stat_pkts  out  CNT_WIDTH  completed packets
stat_beats  out  CNT_WIDTH  accepted beats
stat_stall  out  CNT_WIDTH  cycles with tvalid=1 and tready=0

Behaviour:
- Reset: state=IDLE. tvalid=0, tlast=0, tdata=0, tdest=0, busy=0, done=0, all stats=0, round-robin pointer=0. Reset mid-packet drops tvalid on the next edge. The partial packet is abandoned, and the mesh must be reset alongside this block.
- Effective mask = cfg_dest_mask, with bit SRC_ID cleared if DISABLE_SELFLOOP=1. All config is latched on an accepted start and ignored afterwards.
- FSM:
  - IDLE/DONE --start--> SEND if effective mask != 0. Otherwise go to DONE with stats cleared.
  - An accepted start clears stats, the packet index and the rr pointer.
  - SEND: tvalid=1 from the first cycle after start (latency 1). A beat transfers when tvalid&&tready. The beat index increments on each transfer.
  - On the tlast transfer: stat_pkts++. If the packet count is reached or abort is high, go to DONE. Else if gap=0, the next packet's first beat is valid in the very next cycle (no bubble). Else go to GAP.
  - GAP: tvalid=0 for exactly cfg_gap cycles, then SEND. Abort seen in GAP goes to DONE.
  - Abort never truncates a packet mid-stream; framing is always preserved.
- AXIS rules: once tvalid=1, tdata, tdest and tlast are held stable until the transfer. tvalid never falls without a transfer except on rst. tready may toggle freely; outputs do not depend combinationally on tready.
- Payload per beat:
  - tdata[TDATA_WIDTH-1 -: TDEST_WIDTH] = SRC_ID
  - tdata[15:8] = packet index mod 256
  - tdata[7:0] = beat index
  - all other bits 0
- tlast=1 on beat pkt_len-1.
- Destination: fixed per packet. It is the next set mask bit at or after the rr pointer, with wrap-around. The pointer advances to dest+1 mod NUM_NODES after each packet.
- Counters saturate at all-ones (no wrap). stat_stall counts only in SEND.
- Start in SEND or GAP is ignored. Start in DONE restarts with the new config.

Decomposition:
- Package axis_tg_pkg:
  - state enum (IDLE, SEND, GAP, DONE)
  - payload field offsets: SRC, PKT 15:8, BEAT 7:0
  - a function to clamp pkt_len to >= 1
- Sub-module axis_tg_dest_sel: combinational round-robin find-first-set over the mask, starting from the pointer. Outputs dest and found.

Test Plan:
- Basic: SRC_ID=2, mask=4'b0010, num_pkts=1, len=4, gap=0, tready=1 → 4 beats to tdest=1, tdata=0x2000_0000..0x2000_0003, tlast on beat 3. Then done=1, stat_pkts=1, stat_beats=4.
- Round-robin: mask=4'b1011, num_pkts=5, len=1 → tdest sequence 0,1,3,0,1; back-to-back with no bubble cycles.
- Backpressure: len=3, tready pattern 1,0,0,1,0,1 → tdata/tdest/tlast stable while stalled, stat_stall=3, 3 beats accepted in order.
- Gap/abort: gap=5, num_pkts=0, assert abort during beat 1 of packet 2 → packet 2 completes with tlast, then DONE. Exactly 5 idle cycles appear between packets 0→1 and 1→2.
- Self-loop: DISABLE_SELFLOOP=1, SRC_ID=1, mask=4'b0010 → start goes straight to DONE, no tvalid, stats=0.
- Reset mid-packet: rst during beat 2 of 4 → tvalid=0 the next cycle, all outputs at reset values. A new start sends packet index 0 again.
